// File: rtl/pipe_sched_pkg.sv
// Shared types and defaults for the two-requester pipeline scheduler.
// Round-robin arbitration is selected by defining PIPE_SCHED_RR_EN.
package pipe_sched_pkg;

    localparam int PIPE_WIDTH  = 8;
    localparam int PIPE_STAGES = 3;

    typedef logic id_t;

    typedef struct packed {
        logic                  valid;
        id_t                   id;
        logic [PIPE_WIDTH-1:0] data;
    } stage_t;

endpackage : pipe_sched_pkg

// File: rtl/pipe_sched_stage.sv
// One pipeline stage: a stage_t register that loads only when the pipe advances.
module pipe_sched_stage
    import pipe_sched_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t stage_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (advance_i) begin
            stage_q <= d_i;
        end
    end

    assign q_o = stage_q;

endmodule : pipe_sched_stage

// File: rtl/pipe_sched.sv
// Two-requester scheduler feeding a STAGES-deep register pipeline with global stall.
// Define PIPE_SCHED_RR_EN for round-robin ties; otherwise requester 0 has fixed priority.
module pipe_sched
    import pipe_sched_pkg::*;
#(
    parameter int WIDTH  = PIPE_WIDTH,
    parameter int STAGES = PIPE_STAGES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req0_valid,
    input  logic [WIDTH-1:0]            req0_data,
    output logic                        req0_ready,
    input  logic                        req1_valid,
    input  logic [WIDTH-1:0]            req1_data,
    output logic                        req1_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_id,
    input  logic                        out_ready,
    output logic [$clog2(STAGES+1)-1:0] inflight
);

    localparam int CNT_W = $clog2(STAGES + 1);

    logic   advance;
    logic   grant_valid;
    id_t    grant_id;
    id_t    tie_winner;
    stage_t stage_in;
    stage_t stage_q [STAGES];
    logic [CNT_W-1:0] count;

    assign advance = !out_valid || out_ready;

`ifdef PIPE_SCHED_RR_EN
    id_t last_q;

    // Reset value 1 hands the very first tie to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance && grant_valid) begin
            last_q <= grant_id;
        end
    end

    assign tie_winner = ~last_q;
`else
    assign tie_winner = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_valid = req0_valid || req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = tie_winner;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = advance && grant_valid && (grant_id == 1'b0);
    assign req1_ready = advance && grant_valid && (grant_id == 1'b1);

    // A bubble keeps the previous head data/ID so idle cycles cause no data toggling.
    always_comb begin
        stage_in       = stage_q[0];
        stage_in.valid = 1'b0;
        if (grant_valid) begin
            stage_in.valid = 1'b1;
            stage_in.id    = grant_id;
            stage_in.data  = grant_id ? req1_data : req0_data;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            pipe_sched_stage u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .advance_i (advance),
                .d_i       (stage_in),
                .q_o       (stage_q[g])
            );
        end else begin : g_body
            pipe_sched_stage u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .advance_i (advance),
                .d_i       (stage_q[g-1]),
                .q_o       (stage_q[g])
            );
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + CNT_W'(stage_q[i].valid);
        end
    end

    assign inflight  = count;
    assign out_valid = stage_q[STAGES-1].valid;
    assign out_id    = stage_q[STAGES-1].id;
    assign out_data  = stage_q[STAGES-1].data;

endmodule : pipe_sched

// File: tb/tb_pipe_sched.sv
// Directed self-checking bench for pipe_sched; expectations follow PIPE_SCHED_RR_EN when defined.
module tb_pipe_sched;
    import pipe_sched_pkg::*;

    localparam int W  = PIPE_WIDTH;
    localparam int S  = PIPE_STAGES;
    localparam int CW = $clog2(S + 1);

    localparam logic [3:0] SINGLE_OV      = 4'b0100;
    localparam int         SINGLE_INF [4] = '{1, 1, 1, 0};
    localparam logic [6:0] GAP_OV         = 7'b0101000;
    localparam int         GAP_INF [7]    = '{0, 1, 1, 2, 1, 1, 0};

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          out_valid, out_id, out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] inflight;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .inflight   (inflight)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {id, data} of the k-th word delivered when both producers stream from reset.
    function automatic logic [W:0] exp_word(input int k);
        logic [W-1:0] base0, base1;
        base0 = 8'h20;
        base1 = 8'hA0;
`ifdef PIPE_SCHED_RR_EN
        if (k % 2 == 0) return {1'b0, base0 + W'(k / 2)};
        else            return {1'b1, base1 + W'(k / 2)};
`else
        return {1'b0, base0 + W'(k)};
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, out_id, out_data, inflight} !== '0)
            $display("FAIL reset_outputs: got v=%b id=%b d=%h inf=%0d required all zero",
                     out_valid, out_id, out_data, inflight);
        else n_pass++;
        req0_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL reset_ready: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
        else n_pass++;
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (inflight !== '0)
            $display("FAIL reset_idle_inflight: got %0d required 0", inflight);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        out_ready  = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL single_ready: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (out_valid !== SINGLE_OV[j] || inflight !== CW'(SINGLE_INF[j]))
                $display("FAIL single_pipe[%0d]: got v=%b inf=%0d required v=%b inf=%0d",
                         j, out_valid, inflight, SINGLE_OV[j], SINGLE_INF[j]);
            else n_pass++;
            if (j == 2) begin
                n_checks++;
                if ({out_id, out_data} !== {1'b0, 8'h11})
                    $display("FAIL single_word: got id=%b d=%h required id=0 d=11", out_id, out_data);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Both producers stream; mode 0 = consumer always ready, 1 = stall window, 2 = ready toggles.
    task automatic run_stream(input string name, input int n, input int mode, input int exp_words);
        logic [W-1:0] d0, d1;
        logic [W:0]   ew;
        logic         acc0, acc1;
        int           k;
        d0   = 8'h20;
        d1   = 8'hA0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        k    = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (acc0) d0++;
            if (acc1) d1++;
            req0_data = d0;
            req1_data = d1;
            case (mode)
                1:       out_ready = !(i >= 5 && i <= 8);
                2:       out_ready = (i % 2 == 0);
                default: out_ready = 1'b1;
            endcase
            #1;
            acc0 = req0_ready;
            acc1 = req1_ready;
            n_checks++;
            if ((req0_ready && req1_ready) !== 1'b0)
                $display("FAIL %s_one_ready[%0d]: got r0=%b r1=%b required at most one", name, i, req0_ready, req1_ready);
            else n_pass++;
`ifndef PIPE_SCHED_RR_EN
            n_checks++;
            if (req1_ready !== 1'b0)
                $display("FAIL %s_fixed_r1[%0d]: got r1=%b required 0", name, i, req1_ready);
            else n_pass++;
`endif
            ew = exp_word(k);
            if (mode == 1 && i >= 5 && i <= 8) begin
                n_checks++;
                if ({req0_ready, req1_ready} !== 2'b00 || inflight !== CW'(3) ||
                    {out_valid, out_id, out_data} !== {1'b1, ew})
                    $display("FAIL %s_hold[%0d]: got r=%b%b inf=%0d v=%b id=%b d=%h required r=00 inf=3 v=1 id=%b d=%h",
                             name, i, req0_ready, req1_ready, inflight, out_valid, out_id, out_data, ew[W], ew[W-1:0]);
                else n_pass++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if ({out_id, out_data} !== ew)
                    $display("FAIL %s_word[%0d]: got id=%b d=%h required id=%b d=%h",
                             name, k, out_id, out_data, ew[W], ew[W-1:0]);
                else n_pass++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        n_checks++;
        if (k !== exp_words)
            $display("FAIL %s_count: got %0d words required %0d", name, k, exp_words);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_stream("b2b", 12, 0, 9);
    endtask

    task automatic test_stall();
        do_reset();
        run_stream("stall", 14, 1, 7);
    endtask

    task automatic test_gaps();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req0_valid = (i == 0 || i == 2);
            req0_data  = (i == 0) ? 8'h01 : 8'h02;
            #1;
            n_checks++;
            if (out_valid !== GAP_OV[i] || inflight !== CW'(GAP_INF[i]))
                $display("FAIL gap_pipe[%0d]: got v=%b inf=%0d required v=%b inf=%0d",
                         i, out_valid, inflight, GAP_OV[i], GAP_INF[i]);
            else n_pass++;
            if (i == 3 || i == 5) begin
                n_checks++;
                if (out_data !== ((i == 3) ? 8'h01 : 8'h02))
                    $display("FAIL gap_word[%0d]: got %h required %h", i, out_data, (i == 3) ? 8'h01 : 8'h02);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        out_ready  = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (inflight !== CW'(3) || {out_valid, out_data} !== {1'b1, 8'h55})
            $display("FAIL midrst_full: got inf=%0d v=%b d=%h required inf=3 v=1 d=55", inflight, out_valid, out_data);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_id, out_data, inflight} !== '0)
            $display("FAIL midrst_clear: got v=%b id=%b d=%h inf=%0d required all zero",
                     out_valid, out_id, out_data, inflight);
        else n_pass++;
        req1_valid = 1'b1;
        req1_data  = 8'hAA;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL midrst_tie: got r0=%b r1=%b required r0=1 r1=0", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_checks++;
        if (inflight !== CW'(1))
            $display("FAIL midrst_first_accept: got inf=%0d required 1", inflight);
        else n_pass++;
    endtask

    task automatic test_toggle();
        do_reset();
        run_stream("toggle", 20, 2, 8);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_gaps();
        test_reset_mid();
        test_toggle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_sched
